// File: rtl/except_ctrl_pkg.sv
// Shared constants for the exception sequencer:
// exception codes, raw flag bits, CP0 addresses, stall vectors, FSM states.
package except_ctrl_pkg;

  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_INVALID = 32'h0000_000a;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_OVF     = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  localparam int FLAG_SYSCALL = 8;
  localparam int FLAG_INVALID = 9;
  localparam int FLAG_TRAP    = 10;
  localparam int FLAG_OVF     = 11;
  localparam int FLAG_ERET    = 12;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/except_ctrl_int_sync.sv
// Multi-flop level synchroniser for asynchronous interrupt lines.
// Every stage clears on the asynchronous active-low reset.
module int_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // Shift the raw lines through the flop chain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/except_ctrl.sv
// Exception/interrupt sequencer between MEM and cp0_reg.
// Forwards WB mtc0, prioritises exceptions, times the flush.
import except_ctrl_pkg::*;

module except_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_except_i,
  input  logic [31:0] mem_inst_addr_i,
  input  logic        mem_delayslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic [5:0]  int_i,
  output logic [5:0]  int_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] cur_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [5:0]  stall_o,
  output logic        busy_o
);

  localparam logic [2:0] FC = 3'(FLUSH_CYCLES);

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [31:0] status_f;
  logic [31:0] cause_f;
  logic [31:0] epc_f;
  logic        int_pend;
  logic [31:0] exc_code;
  logic        detect;
  logic        unused;

  int_sync #(
    .WIDTH  (6),
    .STAGES (SYNC_STAGES)
  ) u_int_sync (
    .clk (clk),
    .rst (rst),
    .d   (int_i),
    .q   (int_o)
  );

  // Live CP0 view with WB-stage mtc0 forwarded
  always_comb begin
    status_f = cp0_status_i;
    cause_f  = cp0_cause_i;
    epc_f    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      if (wb_cp0_waddr_i == CP0_REG_STATUS)
        status_f = wb_cp0_data_i;
      if (wb_cp0_waddr_i == CP0_REG_CAUSE)
        cause_f[9:8] = wb_cp0_data_i[9:8];
      if (wb_cp0_waddr_i == CP0_REG_EPC)
        epc_f = wb_cp0_data_i;
    end
  end

  assign int_pend = status_f[0] & ~status_f[1]
                  & (|(cause_f[15:8] & status_f[15:8]));

  // Pick the highest-priority exception of the MEM instruction
  always_comb begin
    exc_code = EXC_NONE;
    if (state_q == ST_IDLE && mem_valid_i) begin
      if (int_pend)
        exc_code = EXC_INT;
      else if (mem_except_i[FLAG_SYSCALL])
        exc_code = EXC_SYSCALL;
      else if (mem_except_i[FLAG_INVALID])
        exc_code = EXC_INVALID;
      else if (mem_except_i[FLAG_TRAP])
        exc_code = EXC_TRAP;
      else if (mem_except_i[FLAG_OVF])
        exc_code = EXC_OVF;
      else if (mem_except_i[FLAG_ERET])
        exc_code = EXC_ERET;
    end
  end

  assign detect       = (exc_code != EXC_NONE);
  assign excepttype_o = exc_code;

  // Stall requests yield to any exception or flush in progress
  always_comb begin
    stall_o = STALL_NONE;
    if (state_q == ST_IDLE && !detect) begin
      if (stallreq_ex_i)
        stall_o = STALL_EX;
      else if (stallreq_id_i)
        stall_o = STALL_ID;
    end
  end

  assign cur_inst_addr_o   = mem_inst_addr_i;
  assign is_in_delayslot_o = mem_delayslot_i;

  // Flush sequencer: latch redirect, hold flush for FC cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      flush_o  <= 1'b0;
      new_pc_o <= 32'h0;
      busy_o   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (detect) begin
            state_q  <= ST_FLUSH;
            cnt_q    <= 3'd1;
            flush_o  <= 1'b1;
            busy_o   <= 1'b1;
            new_pc_o <= (exc_code == EXC_ERET)
                      ? epc_f : EXC_VECTOR;
          end
        end
        ST_FLUSH: begin
          if (cnt_q >= FC) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            flush_o <= 1'b0;
            busy_o  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 3'd0;
          flush_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

  assign unused = ^{mem_except_i[31:13], mem_except_i[7:0],
                    status_f[31:16], status_f[7:2],
                    cause_f[31:16], cause_f[7:0]};

endmodule

// File: tb/tb_except_ctrl.sv
// Scoreboard bench for except_ctrl: random + directed stimulus,
// expectations from a cycle-level behavioural model.
module tb_except_ctrl;

  localparam logic [31:0] VEC = 32'h0000_0020;
  localparam int FC = 4;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i;
  logic [31:0] mem_except_i;
  logic [31:0] mem_inst_addr_i;
  logic        mem_delayslot_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic [5:0]  int_i;
  logic [5:0]  int_o;
  logic [31:0] excepttype_o;
  logic [31:0] cur_inst_addr_o;
  logic        is_in_delayslot_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [5:0]  stall_o;
  logic        busy_o;

  except_ctrl #(
    .EXC_VECTOR   (VEC),
    .FLUSH_CYCLES (FC),
    .SYNC_STAGES  (SS)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_valid_i       (mem_valid_i),
    .mem_except_i      (mem_except_i),
    .mem_inst_addr_i   (mem_inst_addr_i),
    .mem_delayslot_i   (mem_delayslot_i),
    .cp0_status_i      (cp0_status_i),
    .cp0_cause_i       (cp0_cause_i),
    .cp0_epc_i         (cp0_epc_i),
    .wb_cp0_we_i       (wb_cp0_we_i),
    .wb_cp0_waddr_i    (wb_cp0_waddr_i),
    .wb_cp0_data_i     (wb_cp0_data_i),
    .stallreq_id_i     (stallreq_id_i),
    .stallreq_ex_i     (stallreq_ex_i),
    .int_i             (int_i),
    .int_o             (int_o),
    .excepttype_o      (excepttype_o),
    .cur_inst_addr_o   (cur_inst_addr_o),
    .is_in_delayslot_o (is_in_delayslot_o),
    .flush_o           (flush_o),
    .new_pc_o          (new_pc_o),
    .stall_o           (stall_o),
    .busy_o            (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] et;
    logic [5:0]  st;
    logic        fl;
    logic [31:0] npc;
    logic        bz;
    logic [5:0]  io;
    logic [31:0] pc;
    logic        ds;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 0;

  int          m_left;
  logic [31:0] m_pc;
  logic [5:0]  m_hist[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, req);
    end
  endtask

  task automatic model_reset();
    m_left = 0;
    m_pc   = 32'h0;
    m_hist.delete();
    for (int i = 0; i < SS; i++) m_hist.push_back(6'h0);
  endtask

  task automatic idle_in();
    mem_valid_i     = 1'b0;
    mem_except_i    = 32'h0;
    mem_inst_addr_i = 32'h0;
    mem_delayslot_i = 1'b0;
    cp0_status_i    = 32'h0;
    cp0_cause_i     = 32'h0;
    cp0_epc_i       = 32'h0;
    wb_cp0_we_i     = 1'b0;
    wb_cp0_waddr_i  = 5'd0;
    wb_cp0_data_i   = 32'h0;
    stallreq_id_i   = 1'b0;
    stallreq_ex_i   = 1'b0;
    int_i           = 6'h0;
  endtask

  // Predict this cycle's outputs from current inputs, then advance
  task automatic eval_push();
    logic [31:0] fs, fc, fe, code;
    logic pend;
    exp_t e;
    fs = cp0_status_i;
    fc = cp0_cause_i;
    fe = cp0_epc_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) fs = wb_cp0_data_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13)
      fc[9:8] = wb_cp0_data_i[9:8];
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) fe = wb_cp0_data_i;
    pend = fs[0] && !fs[1] && ((fc[15:8] & fs[15:8]) != 8'h0);
    code = 32'h0;
    if (m_left == 0 && mem_valid_i) begin
      if (pend)                 code = 32'h01;
      else if (mem_except_i[8])  code = 32'h08;
      else if (mem_except_i[9])  code = 32'h0a;
      else if (mem_except_i[10]) code = 32'h0d;
      else if (mem_except_i[11]) code = 32'h0c;
      else if (mem_except_i[12]) code = 32'h0e;
    end
    e.et  = code;
    e.fl  = (m_left > 0);
    e.bz  = (m_left > 0);
    e.npc = m_pc;
    e.io  = m_hist[0];
    e.pc  = mem_inst_addr_i;
    e.ds  = mem_delayslot_i;
    if (m_left > 0 || code != 0) e.st = 6'b000000;
    else if (stallreq_ex_i)      e.st = 6'b001111;
    else if (stallreq_id_i)      e.st = 6'b000111;
    else                         e.st = 6'b000000;
    sb.push_back(e);
    void'(m_hist.pop_front());
    m_hist.push_back(int_i);
    if (m_left > 0) m_left--;
    else if (code != 0) begin
      m_left = FC;
      m_pc   = (code == 32'h0e) ? fe : VEC;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_in();
    #1;
    chk("rst_flush", {31'h0, flush_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_int_o", {26'h0, int_o}, 32'h0);
    chk("rst_new_pc", new_pc_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    eval_push();
  endtask

  task automatic rand_cycle();
    logic [4:0] a;
    @(negedge clk);
    idle_in();
    mem_valid_i     = ($urandom_range(0, 9) < 7);
    mem_except_i    = {19'h0, $urandom_range(0, 31) & $urandom_range(0, 31)
                       & $urandom_range(0, 31), 8'h0}
                    | {24'h0, 8'($urandom)};
    mem_inst_addr_i = $urandom;
    mem_delayslot_i = 1'($urandom);
    cp0_status_i    = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
    cp0_cause_i     = {16'h0, 8'($urandom & $urandom), 8'h0};
    cp0_epc_i       = $urandom;
    wb_cp0_we_i     = ($urandom_range(0, 9) < 3);
    a = 5'($urandom_range(0, 3));
    wb_cp0_waddr_i  = (a == 5'd3) ? 5'($urandom) : 5'd12 + a;
    wb_cp0_data_i   = $urandom;
    stallreq_id_i   = 1'($urandom);
    stallreq_ex_i   = ($urandom_range(0, 3) == 0);
    int_i           = 6'($urandom);
    eval_push();
  endtask

  task automatic dir_cycle(input logic v, input logic [31:0] ex,
                           input logic [31:0] pc, input logic [31:0] st,
                           input logic [31:0] ca, input logic sx);
    @(negedge clk);
    idle_in();
    mem_valid_i     = v;
    mem_except_i    = ex;
    mem_inst_addr_i = pc;
    cp0_status_i    = st;
    cp0_cause_i     = ca;
    stallreq_ex_i   = sx;
    eval_push();
  endtask

  // Monitor: pop and compare every cycle the driver predicted
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("excepttype", excepttype_o, e.et);
        chk("stall", {26'h0, stall_o}, {26'h0, e.st});
        chk("flush", {31'h0, flush_o}, {31'h0, e.fl});
        chk("busy", {31'h0, busy_o}, {31'h0, e.bz});
        chk("int_o", {26'h0, int_o}, {26'h0, e.io});
        chk("cur_pc", cur_inst_addr_o, e.pc);
        chk("delayslot", {31'h0, is_in_delayslot_o}, {31'h0, e.ds});
        if (e.fl) chk("new_pc", new_pc_o, e.npc);
      end
    end
  end

  initial begin
    rst = 1'b0;
    idle_in();
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();
    // syscall, full flush window
    dir_cycle(1, 32'h100, 32'h100, 32'h1000_0000, 0, 0);
    repeat (FC + 1) dir_cycle(0, 0, 0, 0, 0, 0);
    // eret with forwarded EPC
    @(negedge clk);
    idle_in();
    mem_valid_i = 1; mem_except_i = 32'h1000;
    mem_inst_addr_i = 32'h200; cp0_epc_i = 32'h104;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h300;
    eval_push();
    repeat (FC + 1) dir_cycle(0, 0, 0, 0, 0, 0);
    // interrupt line sync, then interrupt taken / masked by EXL
    repeat (3) begin
      @(negedge clk); idle_in(); int_i = 6'h1; eval_push();
    end
    dir_cycle(1, 0, 32'h40, 32'h401, 32'h400, 0);
    repeat (FC + 1) dir_cycle(0, 0, 0, 0, 0, 0);
    dir_cycle(1, 0, 32'h44, 32'h403, 32'h400, 0);
    // priority pairs
    dir_cycle(1, 32'h900, 32'h48, 0, 0, 0);
    repeat (FC + 1) dir_cycle(0, 0, 0, 0, 0, 0);
    dir_cycle(1, 32'h400, 32'h4c, 32'h401, 32'h400, 0);
    repeat (FC + 1) dir_cycle(0, 0, 0, 0, 0, 0);
    // stall then exception beats stall
    dir_cycle(1, 0, 32'h50, 0, 0, 1);
    dir_cycle(1, 32'h100, 32'h54, 0, 0, 1);
    dir_cycle(1, 0, 32'h58, 0, 0, 1);
    // reset mid-flush, then normal acceptance
    dir_cycle(1, 32'h100, 32'h60, 0, 0, 0);
    dir_cycle(0, 0, 0, 0, 0, 0);
    do_reset();
    dir_cycle(1, 32'h200, 32'h64, 0, 0, 0);
    repeat (FC + 1) dir_cycle(0, 0, 0, 0, 0, 0);
    // random phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      else rand_cycle();
    end
    @(negedge clk);
    idle_in();
    #5;
    done = 1;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
